// File: rtl/rd_empty_sync_if.sv
`default_nettype none
// ============================================================================
// Module      : rd_empty_sync_if
// Description : Signal bundle between the read-domain flag generator and its
//               neighbours (write-domain pointer input, read pointer logic).
//               slave  - rd_empty_sync side (consumes pointers, drives flags)
//               master - surrounding read logic / environment side
// Ports       : wr_gray_ptr  write pointer, Gray, asynchronous to clk_r
//               read_adr     binary read pointer from read logic
//               FIFO_empty   empty flag, read domain
//               rd_gray_ptr  registered Gray read pointer for export
//               rd_level     entries available to read
//               almost_empty rd_level <= ae_thresh (optional feature)
//               ptr_err      sticky level-out-of-range flag
// Revision    : 1.0 - initial release
// ============================================================================
interface rd_empty_sync_if #(
  parameter int adr_width = 3
);
  logic [adr_width:0] wr_gray_ptr;
  logic [adr_width:0] read_adr;
  logic               FIFO_empty;
  logic [adr_width:0] rd_gray_ptr;
  logic [adr_width:0] rd_level;
  logic               almost_empty;
  logic               ptr_err;

  modport master (
    output wr_gray_ptr,
    output read_adr,
    input  FIFO_empty,
    input  rd_gray_ptr,
    input  rd_level,
    input  almost_empty,
    input  ptr_err
  );

  modport slave (
    input  wr_gray_ptr,
    input  read_adr,
    output FIFO_empty,
    output rd_gray_ptr,
    output rd_level,
    output almost_empty,
    output ptr_err
  );
endinterface
`default_nettype wire

// File: rtl/rd_empty_sync.sv
`default_nettype none
// ============================================================================
// Module      : rd_empty_sync
// Description : Read-domain flag generator for an asynchronous FIFO.
//               Synchronizes the write Gray pointer into clk_r, compares it
//               with the binary read pointer, and produces the empty flag,
//               the exported Gray read pointer, the read-side fill level and
//               a sticky pointer-error flag.
// Ports       : clk_r  - read-domain clock
//               reset  - asynchronous active-high reset
//               bus    - rd_empty_sync_if.slave (pointers in, flags out)
// Options     : RD_ALMOST_EMPTY_EN - when defined, almost_empty is driven
//               by (rd_level <= ae_thresh); otherwise it is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rd_empty_sync #(
  parameter int depth       = 8,
  parameter int adr_width   = $clog2(depth),
  parameter int sync_stages = 2,
  parameter int ae_thresh   = 2
) (
  input  logic          clk_r,
  input  logic          reset,
  rd_empty_sync_if.slave bus
);

  localparam int                 ptr_w   = adr_width + 1;
  localparam logic [adr_width:0] c_depth = ptr_w'(depth);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter legality
  // --------------------------------------------------------------------------
  generate
    if (depth < 2 || (depth & (depth - 1)) != 0) begin : g_bad_depth
      $error("rd_empty_sync: depth must be a power of two >= 2");
    end
    if (sync_stages < 2 || sync_stages > 4) begin : g_bad_sync
      $error("rd_empty_sync: sync_stages must be in 2..4");
    end
    if (ae_thresh < 1 || ae_thresh > depth - 1) begin : g_bad_ae
      $error("rd_empty_sync: ae_thresh must be in 1..depth-1");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Write-pointer synchronizer: plain flop chain, no logic between stages,
  // so a single-bit Gray step is never seen as an intermediate code.
  // --------------------------------------------------------------------------
  logic [adr_width:0] sync_q [sync_stages];
  logic [adr_width:0] wr_gray_s;

  always_ff @(posedge clk_r or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < sync_stages; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= bus.wr_gray_ptr;
      for (int s = 1; s < sync_stages; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign wr_gray_s = sync_q[sync_stages-1];

  // --------------------------------------------------------------------------
  // Gray <-> binary
  // --------------------------------------------------------------------------
  logic [adr_width:0] rd_gray_now;
  logic [adr_width:0] rd_gray_q;
  logic [adr_width:0] wr_bin_s;

  assign rd_gray_now = bus.read_adr ^ (bus.read_adr >> 1);

  // Each binary bit is the XOR of all Gray bits at and above it, which is the
  // MSB-down XOR chain unrolled per bit.
  generate
    for (genvar i = 0; i <= adr_width; i++) begin : g_g2b
      assign wr_bin_s[i] = ^wr_gray_s[adr_width:i];
    end
  endgenerate

  // Exported pointer is registered so the write domain never samples a
  // combinational glitch; the one-cycle lag only makes the write side see
  // the FIFO slightly fuller than it is, which is safe.
  always_ff @(posedge clk_r or posedge reset) begin
    if (reset) begin
      rd_gray_q <= '0;
    end else begin
      rd_gray_q <= rd_gray_now;
    end
  end

  assign bus.rd_gray_ptr = rd_gray_q;

  // --------------------------------------------------------------------------
  // Empty and level. Both use the live read_adr so the read that drains the
  // last entry raises empty in the same cycle, blocking a further read.
  // --------------------------------------------------------------------------
  logic [adr_width:0] level;

  assign bus.FIFO_empty = (wr_gray_s == rd_gray_now);
  // Modulo 2^(adr_width+1) subtraction absorbs wrap of either pointer.
  assign level          = wr_bin_s - bus.read_adr;
  assign bus.rd_level   = level;

  // --------------------------------------------------------------------------
  // Sticky pointer error: a level above depth can only arise from corrupted
  // or mis-synchronized pointers; it holds until reset.
  // --------------------------------------------------------------------------
  logic ptr_err_q;

  always_ff @(posedge clk_r or posedge reset) begin
    if (reset) begin
      ptr_err_q <= 1'b0;
    end else if (level > c_depth) begin
      ptr_err_q <= 1'b1;
    end
  end

  assign bus.ptr_err = ptr_err_q;

  // --------------------------------------------------------------------------
  // Almost-empty
  // --------------------------------------------------------------------------
`ifdef RD_ALMOST_EMPTY_EN
  localparam logic [adr_width:0] c_ae = ptr_w'(ae_thresh);
  assign bus.almost_empty = (level <= c_ae);
`else
  assign bus.almost_empty = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rd_empty_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_rd_empty_sync
// Description : Self-checking bench for rd_empty_sync (depth 8, 2 sync
//               stages, ae_thresh 2). Table-driven steady-state vectors with
//               a scoreboard queue, plus hand-written multi-cycle sequences
//               for reset, sync latency, drain, wrap, full/error and
//               almost-empty. Honours RD_ALMOST_EMPTY_EN like the design.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rd_empty_sync;

  logic clk_r = 1'b0;
  logic reset = 1'b1;

  always #5 clk_r = ~clk_r;

  rd_empty_sync_if #(.adr_width(3)) bus ();

  rd_empty_sync #(
    .depth      (8),
    .sync_stages(2),
    .ae_thresh  (2)
  ) dut (
    .clk_r(clk_r),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] wr_gray;
    logic [3:0] radr;
    logic [3:0] level;
    logic       empty;
    logic [3:0] rd_gray;
  } vec_t;

  typedef struct {
    logic [3:0] level;
    logic       empty;
    logic [3:0] rd_gray;
    logic       ae;
    logic       err;
  } exp_t;

  vec_t vecs [12];
  exp_t sbq [$];

  function automatic logic ae_of(input logic [3:0] lvl);
`ifdef RD_ALMOST_EMPTY_EN
    return (lvl <= 4'd2);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reset applied mid-cycle (asynchronous), held over one rising edge.
  task automatic apply_reset(input logic [3:0] wg, input logic [3:0] ra);
    @(negedge clk_r);
    bus.wr_gray_ptr = wg;
    bus.read_adr    = ra;
    reset           = 1'b1;
    @(negedge clk_r);
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : test
    exp_t e;
    // wr_gray, radr, level, empty, rd_gray(radr)
    vecs[0]  = '{4'b0000, 4'd0,  4'd0, 1'b1, 4'b0000};
    vecs[1]  = '{4'b0001, 4'd0,  4'd1, 1'b0, 4'b0000};
    vecs[2]  = '{4'b0011, 4'd1,  4'd1, 1'b0, 4'b0001};
    vecs[3]  = '{4'b0110, 4'd1,  4'd3, 1'b0, 4'b0001};
    vecs[4]  = '{4'b0111, 4'd5,  4'd0, 1'b1, 4'b0111};
    vecs[5]  = '{4'b1100, 4'd5,  4'd3, 1'b0, 4'b0111};
    vecs[6]  = '{4'b1010, 4'd6,  4'd6, 1'b0, 4'b0101};
    vecs[7]  = '{4'b1001, 4'd9,  4'd5, 1'b0, 4'b1101};
    vecs[8]  = '{4'b0001, 4'd12, 4'd5, 1'b0, 4'b1010};
    vecs[9]  = '{4'b0110, 4'd15, 4'd5, 1'b0, 4'b1000};
    vecs[10] = '{4'b0100, 4'd15, 4'd8, 1'b0, 4'b1000};
    vecs[11] = '{4'b0100, 4'd7,  4'd0, 1'b1, 4'b0100};

    bus.wr_gray_ptr = 4'b0101;
    bus.read_adr    = 4'd0;

    // ---------------- Reset with wr_gray_ptr = 0101 ------------------------
    @(negedge clk_r);
    reset = 1'b0;
    @(negedge clk_r);
    @(negedge clk_r);
    reset = 1'b1;
    #1;
    chk("rst_async_empty",  bus.FIFO_empty,  1);
    chk("rst_async_rdgray", bus.rd_gray_ptr, 0);
    chk("rst_async_level",  bus.rd_level,    0);
    chk("rst_async_err",    bus.ptr_err,     0);
    chk("rst_async_ae",     bus.almost_empty, ae_of(4'd0));
    @(negedge clk_r);
    chk("rst_hold_empty", bus.FIFO_empty, 1);
    chk("rst_hold_level", bus.rd_level,   0);
    reset = 1'b0;
    @(negedge clk_r);
    chk("rst_rel1_empty", bus.FIFO_empty, 1);
    chk("rst_rel1_level", bus.rd_level,   0);
    @(negedge clk_r);
    chk("rst_rel2_empty", bus.FIFO_empty, 0);
    chk("rst_rel2_level", bus.rd_level,   6);

    // ---------------- Sync latency then read drain ------------------------
    apply_reset(4'b0000, 4'd0);
    @(negedge clk_r);
    bus.wr_gray_ptr = 4'b0001;
    @(negedge clk_r);
    chk("lat1_empty", bus.FIFO_empty, 1);
    chk("lat1_level", bus.rd_level,   0);
    @(negedge clk_r);
    chk("lat2_empty", bus.FIFO_empty, 0);
    chk("lat2_level", bus.rd_level,   1);
    bus.read_adr = 4'd1;
    #1;
    chk("drain_empty_now",  bus.FIFO_empty,  1);
    chk("drain_level_now",  bus.rd_level,    0);
    chk("drain_rdgray_old", bus.rd_gray_ptr, 0);
    @(negedge clk_r);
    chk("drain_rdgray_new", bus.rd_gray_ptr, 4'b0001);

    // ---------------- Wrap: read 15->0, write 15->0->1 --------------------
    apply_reset(4'b1000, 4'd15);
    repeat (3) @(negedge clk_r);
    chk("wrap0_level", bus.rd_level,   0);
    chk("wrap0_empty", bus.FIFO_empty, 1);
    bus.wr_gray_ptr = 4'b0000;
    @(posedge clk_r);
    @(posedge clk_r);
    #1;
    bus.read_adr = 4'd0;   // read pointer register advances with the sync edge
    @(negedge clk_r);
    chk("wrap1_level", bus.rd_level,   0);
    chk("wrap1_empty", bus.FIFO_empty, 1);
    bus.wr_gray_ptr = 4'b0001;
    repeat (2) @(negedge clk_r);
    chk("wrap2_level", bus.rd_level,   1);
    chk("wrap2_empty", bus.FIFO_empty, 0);
    chk("wrap2_err",   bus.ptr_err,    0);

    // ---------------- Full and pointer error ------------------------------
    apply_reset(4'b0000, 4'd0);
    bus.wr_gray_ptr = 4'b1100;
    repeat (3) @(negedge clk_r);
    chk("full_level", bus.rd_level,   8);
    chk("full_empty", bus.FIFO_empty, 0);
    chk("full_err",   bus.ptr_err,    0);
    bus.wr_gray_ptr = 4'b1101;
    repeat (3) @(negedge clk_r);
    chk("over_level", bus.rd_level, 9);
    chk("over_err",   bus.ptr_err,  1);
    bus.wr_gray_ptr = 4'b0000;
    repeat (3) @(negedge clk_r);
    chk("sticky_level", bus.rd_level, 0);
    chk("sticky_err",   bus.ptr_err,  1);
    reset = 1'b1;
    #1;
    chk("err_cleared", bus.ptr_err, 0);
    @(negedge clk_r);
    reset = 1'b0;

    // ---------------- Almost empty: level 3 -> 2 -> 1 -> 0 -----------------
    apply_reset(4'b0010, 4'd0);
    repeat (3) @(negedge clk_r);
    chk("ae_lvl3", bus.almost_empty, ae_of(4'd3));
    chk("ae_lvl3_level", bus.rd_level, 3);
    for (int r = 1; r <= 3; r++) begin
      bus.read_adr = 4'(r);
      @(negedge clk_r);
      chk($sformatf("ae_lvl%0d", 3 - r), bus.almost_empty, ae_of(4'(3 - r)));
    end

    // ---------------- Table-driven steady-state vectors --------------------
    apply_reset(4'b0000, 4'd0);
    repeat (3) @(negedge clk_r);
    for (int v = 0; v < 12; v++) begin
      // Write first, then read, so transient levels stay within depth.
      bus.wr_gray_ptr = vecs[v].wr_gray;
      sbq.push_back('{vecs[v].level, vecs[v].empty, vecs[v].rd_gray,
                      ae_of(vecs[v].level), 1'b0});
      repeat (3) @(negedge clk_r);
      bus.read_adr = vecs[v].radr;
      repeat (2) @(negedge clk_r);
      if (sbq.size() == 0) begin
        chk($sformatf("vec%0d_sb_empty", v), 1, 0);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("vec%0d_level", v),  bus.rd_level,     e.level);
        chk($sformatf("vec%0d_empty", v),  bus.FIFO_empty,   e.empty);
        chk($sformatf("vec%0d_rdgray", v), bus.rd_gray_ptr,  e.rd_gray);
        chk($sformatf("vec%0d_ae", v),     bus.almost_empty, e.ae);
        chk($sformatf("vec%0d_err", v),    bus.ptr_err,      e.err);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rd_empty_sync.md
Name: rd_empty_sync

Overview:
- Read-domain flag generator for the asynchronous FIFO.
- Sits directly upstream of the read pointer logic and drives its FIFO_empty input.
- Accepts the write-domain Gray pointer, synchronizes it into clk_r, and compares it against the binary read pointer (read_adr) returned by the read logic.
- Produces: empty flag, registered Gray read pointer for export to the write domain, read-side fill level, and a sticky pointer-error flag.

Parameters:
- depth, 8: FIFO entries; power of two, >= 2.
- adr_width, $clog2(depth): address bits; pointers are adr_width+1 bits (extra wrap bit).
- sync_stages, 2: flop stages in the write-pointer synchronizer; legal range 2..4.
- ae_thresh, 2: almost-empty threshold in entries; legal range 1..depth-1.

Ports:
- clk_r  in  1  read-domain clock
- reset  in  1  asynchronous, active-high reset
- wr_gray_ptr  in  adr_width+1  write pointer, Gray coded, from write domain (asynchronous to clk_r)
- read_adr  in  adr_width+1  binary read pointer, registered in read logic on clk_r
- FIFO_empty  out  1  FIFO empty, read domain
- rd_gray_ptr  out  adr_width+1  registered Gray read pointer, to write-domain synchronizer
- rd_level  out  adr_width+1  entries available to read, 0..depth
- almost_empty  out  1  rd_level <= ae_thresh (see Optional Feature)
- ptr_err  out  1  sticky: computed level exceeded depth

Behaviour:
- Clocking and reset: one clock (clk_r); reset is asynchronous and active-high. All flops clear on posedge reset with no clock required.
- Reset values:
  - synchronizer stages = 0
  - rd_gray_ptr = 0
  - ptr_err = 0
  - FIFO_empty = 1, rd_level = 0, almost_empty = 1 (given read_adr = 0 during reset)
- Synchronizer:
  - sync_stages-deep flop chain on clk_r samples wr_gray_ptr. Output is wr_gray_s.
  - No logic between stages.
  - A single-bit Gray step on wr_gray_ptr appears on wr_gray_s exactly sync_stages clk_r edges later.
- Gray conversion:
  - rd_gray_ptr <= read_adr ^ (read_adr >> 1), registered on clk_r, one cycle after read_adr.
  - Export must be registered (glitch-free crossing).
  - The one-cycle lag is conservative for the write side and is intentional.
- Empty:
  - FIFO_empty = (wr_gray_s == bin2gray(read_adr)), combinational from flops only.
  - Updates in the same cycle read_adr advances, so the last read asserts empty before any further read enable. No over-read.
- Level:
  - wr_bin_s = gray2bin(wr_gray_s), MSB-down XOR chain.
  - rd_level = (wr_bin_s - read_adr) modulo 2^(adr_width+1), combinational.
  - Wrap-around of either pointer is handled by the modulo arithmetic.
  - rd_level == 0 exactly when FIFO_empty == 1.
- Pointer error:
  - If rd_level > depth on any clk_r edge, ptr_err <= 1 and holds until reset.
  - Other outputs continue to follow their equations.
- Simultaneous read advance and synchronized write advance in one cycle: both applied; level nets to the previous value.
- Reset mid-operation: all state cleared asynchronously. Outputs reflect reset values while reset is high, independent of wr_gray_ptr.

Optional Feature:
- Macro: RD_ALMOST_EMPTY_EN.
- Defined: almost_empty = (rd_level <= ae_thresh), combinational, same timing as FIFO_empty.
- Undefined: almost_empty tied to 0; no comparator logic; ae_thresh is unused.
- The port exists in both builds.

Test Plan:
- Reset: assert reset with wr_gray_ptr=5 (0101) -> FIFO_empty=1, rd_gray_ptr=0, rd_level=0, ptr_err=0; stays so until sync_stages edges after release.
- Sync latency: reset released, read_adr=0, wr_gray_ptr 0->1 -> FIFO_empty falls and rd_level=1 exactly 2 clk_r edges later, not earlier.
- Read drain: level 1, read_adr 0->1 -> FIFO_empty=1 in the same cycle; rd_gray_ptr=0001 one edge later.
- Wrap (depth 8): read_adr 15->0 while wr_bin goes 15->0->1 (Gray 1000->0000->0001) -> rd_level 0->0->1, empty 1->1->0, ptr_err stays 0.
- Full and error: read_adr=0, wr Gray for 8 (1100) -> rd_level=8, FIFO_empty=0, ptr_err=0; then Gray for 9 (1101) -> ptr_err=1, still 1 after wr returns to 0, cleared only by reset.
- Almost empty (macro defined, ae_thresh=2): rd_level 3->2->1->0 -> almost_empty 0->1->1->1. Macro undefined: almost_empty=0 throughout.
